// File: rtl/ram_port_arbiter_if.sv
// Bundles the requester-side handshake and the shared RAM port into one bus.
// The arbiter uses the slave modport. The requesters and the RAM use the master modport.
interface ram_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AWID = 8,
  parameter int DWID = 16
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*AWID-1:0] req_addr;
  logic [NREQ*DWID-1:0] req_din;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [DWID-1:0]      rdata;
  logic                 ram_we;
  logic [AWID-1:0]      ram_addr;
  logic [DWID-1:0]      ram_din;
  logic [DWID-1:0]      ram_dout;

  modport master (
    output req, req_we, req_addr, req_din, ram_dout,
    input  gnt, rvalid, rdata, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  req, req_we, req_addr, req_din, ram_dout,
    output gnt, rvalid, rdata, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one RAM port (1-cycle read latency) among NREQ requesters.
// A requester may hold the port for at most MAX_BURST consecutive grants. Read data returns with a one-hot strobe.
module ram_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int AWID      = 8,
  parameter int DWID      = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  ram_port_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [3:0]      r_burst_cnt;
  logic [NREQ-1:0] r_rvalid;

  logic            w_keep;
  logic            w_found;
  logic            w_any;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_gidx;
  logic [NREQ-1:0] w_gnt;
  int              w_idx;

  // r_ptr always points one past the latest owner, so the cyclic search reaches the old owner last.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found) begin
        w_idx = (int'(r_ptr) + k) % NREQ;
        if (bus.req[w_idx]) begin
          w_found = 1'b1;
          w_win   = IW'(w_idx);
        end
      end
    end
  end

  assign w_keep = (r_state == OWN) && bus.req[r_owner] && (r_burst_cnt < 4'(MAX_BURST));
  assign w_gidx = w_keep ? r_owner : w_win;
  assign w_any  = !rst && (w_keep || w_found);
  assign w_gnt  = w_any ? (NREQ'(1) << w_gidx) : '0;

  // Grant cycle: the RAM port is driven combinationally from the granted requester.
  assign bus.gnt      = w_gnt;
  assign bus.ram_we   = w_any && bus.req_we[w_gidx];
  assign bus.ram_addr = w_any ? bus.req_addr[w_gidx*AWID +: AWID] : '0;
  assign bus.ram_din  = w_any ? bus.req_din[w_gidx*DWID +: DWID] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_burst_cnt <= '0;
      r_rvalid    <= '0;
    end else begin
      r_rvalid <= w_gnt & ~bus.req_we;
      if (w_keep) begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end else if (w_found) begin
        r_state     <= OWN;
        r_owner     <= w_win;
        r_burst_cnt <= 4'd1;
        r_ptr       <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end else begin
        r_state <= IDLE;
      end
    end
  end

  // Return stage: the strobe is registered. The data passes straight through from the RAM output register.
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = bus.ram_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed scoreboard bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_port_arbiter;
  localparam int NREQ = 4;
  localparam int AWID = 8;
  localparam int DWID = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_port_arbiter_if #(.NREQ(NREQ), .AWID(AWID), .DWID(DWID)) bus ();

  ram_port_arbiter #(.NREQ(NREQ), .AWID(AWID), .DWID(DWID), .MAX_BURST(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM model: read-first and registered. Unwritten locations read back as C000+addr.
  logic [15:0] mem [256];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 + 16'(i);
      mem_init <= 1'b1;
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  logic [3:0]  r_req;
  logic [3:0]  r_we;
  logic [7:0]  a [4];
  logic [15:0] d [4];

  assign bus.req      = r_req;
  assign bus.req_we   = r_we;
  assign bus.req_addr = {a[3], a[2], a[1], a[0]};
  assign bus.req_din  = {d[3], d[2], d[1], d[0]};

  typedef struct {
    logic [3:0]  v;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];
  exp_t m_e;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1. Checks the grant-cycle outputs and queues the expected read return.
  task automatic tick(input string name, input int g, input logic [15:0] exp_rd, input bit drop = 1'b0);
    logic [3:0] eg;
    eg = (g < 0) ? 4'b0000 : 4'(1 << g);
    #2;
    chk({name, ".gnt"}, 32'(bus.gnt), 32'(eg));
    if (g >= 0) begin
      chk({name, ".ram_addr"}, 32'(bus.ram_addr), 32'(a[g]));
      chk({name, ".ram_we"}, 32'(bus.ram_we), 32'(r_we[g]));
      if (r_we[g]) chk({name, ".ram_din"}, 32'(bus.ram_din), 32'(d[g]));
      else if (!drop) q.push_back('{eg, exp_rd});
    end else begin
      chk({name, ".ram_we"}, 32'(bus.ram_we), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r_req = 4'b0000;
    r_we  = 4'b0000;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation for every read-return strobe and checks the invariants.
  always @(negedge clk) begin
    if (bus.rvalid !== 4'b0000) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rvalid: got %b expected none", bus.rvalid);
      end else begin
        m_e = q.pop_front();
        chk("rvalid", 32'(bus.rvalid), 32'(m_e.v));
        chk("rdata", 32'(bus.rdata), 32'(m_e.data));
      end
    end
    if ($countones(bus.gnt) > 1 || (bus.gnt & ~bus.req) != 4'b0 ||
        (bus.ram_we && bus.gnt == 4'b0) || $countones(bus.rvalid) > 1) begin
      n_vec++;
      n_err++;
      $display("FAIL invariant: gnt %b req %b ram_we %b rvalid %b", bus.gnt, bus.req, bus.ram_we, bus.rvalid);
    end
  end

  initial begin
    r_req = 4'b0001;
    r_we  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a[i] = 8'h00;
      d[i] = 16'h0000;
    end
    #3;
    chk("reset.gnt", 32'(bus.gnt), 32'd0);
    chk("reset.ram_we", 32'(bus.ram_we), 32'd0);
    chk("reset.rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset.ram_addr", 32'(bus.ram_addr), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    r_req = 4'b0000;

    // Write 0x1234 to 0x10, then read it back.
    a[0] = 8'h10; d[0] = 16'h1234; r_we[0] = 1'b1; r_req = 4'b0001;
    tick("t1_wr", 0, 16'h0);
    r_we[0] = 1'b0;
    tick("t1_rd", 0, 16'h1234);
    r_req = 4'b0000;
    tick("t1_idle", -1, 16'h0);

    // All four requesting. Each gets bursts of four, with no idle cycles.
    do_reset();
    for (int i = 0; i < 4; i++) a[i] = 8'h40 + 8'(i);
    r_req = 4'b1111;
    for (int k = 0; k < 17; k++) tick("t2_rr", (k / 4) % 4, 16'hC040 + 16'((k / 4) % 4));
    r_req = 4'b0000;
    tick("t2_idle", -1, 16'h0);

    // A sole requester re-wins with no gap. Write 0..9, then read back.
    do_reset();
    r_req = 4'b0100; r_we[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a[2] = 8'(k); d[2] = 16'(k);
      tick("t3_wr", 2, 16'h0);
    end
    r_we[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a[2] = 8'(k);
      tick("t3_rd", 2, 16'(k));
    end
    r_req = 4'b0000;
    tick("t3_idle", -1, 16'h0);

    // req0 drops after two grants. req2 gets a fresh burst of four, then the search starts at req3.
    do_reset();
    a[0] = 8'h50; a[2] = 8'h52; a[3] = 8'h53;
    r_req = 4'b0101;
    tick("t4_r0a", 0, 16'hC050);
    tick("t4_r0b", 0, 16'hC050);
    r_req = 4'b1100;
    tick("t4_r2a", 2, 16'hC052);
    r_req = 4'b1101;
    for (int k = 0; k < 3; k++) tick("t4_r2b", 2, 16'hC052);
    tick("t4_r3", 3, 16'hC053);
    r_req = 4'b0000;
    tick("t4_idle", -1, 16'h0);

    // An in-flight read is dropped by an asynchronous reset.
    do_reset();
    a[1] = 8'h61; r_req = 4'b0010;
    tick("t5_rd", 1, 16'h0, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst.rvalid", 32'(bus.rvalid), 32'd0);
    chk("t5_rst.gnt", 32'(bus.gnt), 32'd0);
    chk("t5_rst.ram_we", 32'(bus.ram_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) a[i] = 8'h70 + 8'(i);
    r_req = 4'b1111;
    tick("t5_restart", 0, 16'hC070);
    r_req = 4'b0000;
    tick("t5_idle", -1, 16'h0);

    // req1 writes 0xBEEF to 0x20, then req3 reads 0x20 in the next cycle.
    do_reset();
    a[1] = 8'h20; d[1] = 16'hBEEF; r_we[1] = 1'b1; r_req = 4'b0010;
    tick("t6_wr", 1, 16'h0);
    r_we[1] = 1'b0; a[3] = 8'h20; r_req = 4'b1000;
    tick("t6_rd", 3, 16'hBEEF);
    r_req = 4'b0000;
    tick("t6_idle", -1, 16'h0);
    tick("t6_idle2", -1, 16'h0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one `ram_if.mem`-style RAM port (we/addr/din in, dout out, 1-cycle read latency) among NREQ requesters.
- Uses round-robin arbitration with a bounded burst hold.
- Returns read data to the winning requester with a per-requester valid strobe.
- Placed in front of one port of the dual-port RAM; the other port stays dedicated.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AWID, 8, RAM address width.
- DWID, 16, RAM data width.
- MAX_BURST, 4, max consecutive grants to one requester while others wait (1..15).

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester access request, held until granted.
- req_we  input  NREQ  1 = write, 0 = read, per requester.
- req_addr  input  NREQ*AWID  packed addresses; requester i at [i*AWID +: AWID].
- req_din  input  NREQ*DWID  packed write data; requester i at [i*DWID +: DWID].
- gnt  output  NREQ  one-hot grant; access accepted in the cycle gnt[i]=1.
- rvalid  output  NREQ  one-hot read-data strobe, one cycle after a granted read.
- rdata  output  DWID  read data, valid when any rvalid bit is 1.
- ram_we  output  1  to RAM port we.
- ram_addr  output  AWID  to RAM port addr.
- ram_din  output  DWID  to RAM port din.
- ram_dout  input  DWID  from RAM port dout (registered in RAM, 1-cycle latency).

Behaviour:
- Reset: state=IDLE, owner=0, ptr=0, burst_cnt=0, rvalid=0.
  - gnt=0 and ram_we=0 while rst=1; ram_addr/ram_din=0 when no grant.
  - Async assert; outputs clear immediately.
  - An in-flight read is dropped: no rvalid after reset.
- States:
  - IDLE: no owner.
  - OWN: owner holds the port, burst_cnt = grants issued to owner in the current burst (1..MAX_BURST).
- Arbitration (combinational, same cycle):
  - Keep condition: state=OWN, req[owner]=1 and burst_cnt<MAX_BURST -> gnt[owner]=1, burst_cnt++.
  - Otherwise: search req cyclically starting at ptr; the first set bit wins; gnt[winner]=1, owner<=winner, burst_cnt<=1, state<=OWN.
  - When a burst ends by exhaustion, ptr<=owner+1 (mod NREQ), so the old owner is searched last. A sole requester therefore re-wins and starts a fresh burst with no idle cycle.
  - When a burst ends because req[owner] drops, ptr<=owner+1 as well.
  - No req set -> gnt=0, state<=IDLE, ptr unchanged.
- Datapath in grant cycle T: ram_we=req_we[g], ram_addr=req_addr[g], ram_din=req_din[g]. All are combinational muxes of the granted requester; RAM samples at the end of T.
- Read return:
  - For a granted read, rvalid[g]=1 in cycle T+1 (registered) and rdata=ram_dout (passthrough) in T+1.
  - Writes produce no rvalid.
- Throughput: one access per cycle; back-to-back reads from different requesters give back-to-back rvalid with different one-hot bits.
- Requester must hold req/req_we/req_addr/req_din stable until the gnt cycle. Changes before grant are legal and are taken as new requests.
- Invariants:
  - gnt and rvalid are at most one-hot.
  - gnt[i]=1 only if req[i]=1.
  - ram_we=1 only with a grant.

Test Plan:
- Reset then req=4'b0001 read addr 0x10 after prior write of 0x1234 -> gnt=0001 at T, ram_addr=0x10, rvalid=0001 and rdata=0x1234 at T+1.
- req=4'b1111 held continuously, MAX_BURST=4 -> grant sequence req0 x4, req1 x4, req2 x4, req3 x4, req0 ...; no idle cycles; burst_cnt wraps to 1 at each change.
- Single requester req=4'b0100 held 10 cycles -> gnt[2]=1 every cycle (burst re-arbitration without gap); writes of 0..9 to addr 0..9 readable back correctly.
- req0 bursting with req2 pending, req0 drops after 2 grants -> req2 granted the next cycle with burst_cnt=1; ptr then points at 3.
- Read granted at T, rst asserted mid-T+1 -> rvalid goes 0 immediately, gnt=0; after release, state IDLE and arbitration restarts from req0.
- Interleaved write by req1 to 0x20 (0xBEEF) then read by req3 of 0x20 the next cycle -> rvalid=1000 with rdata=0xBEEF, and no rvalid for the write cycle.
